// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-pipeline definitions: NOP encoding, default parameters and
// the fetch-buffer entry layout.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FQ_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ready;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_buf.sv
// Circular fetch buffer: entries are allocated at the tail when a request is
// accepted, filled in order as responses return, and popped from the head.
module fetch_buf
  import if_fetch_stage_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               alloc_i,
  input  logic [31:0]        alloc_pc_i,
  input  logic               fill_i,
  input  logic [31:0]        fill_instr_i,
  input  logic               pop_i,
  output fetch_entry_t       head_o,
  output logic [CNT_W-1:0]   ready_cnt_o
);

  fetch_entry_t     entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] ready_cnt_q, ready_cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    ready_cnt_d = ready_cnt_q + CNT_W'(fill_i) - CNT_W'(pop_i);
    if (pop_i)   head_d = ptr_inc(head_q);
    if (alloc_i) tail_d = ptr_inc(tail_q);
    if (fill_i)  fill_d = ptr_inc(fill_q);
  end

  // The ready flag doubles as the entry-valid bit, so clearing it is enough
  // to flush; pc/instr payloads need no reset.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      ready_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].ready <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      ready_cnt_q <= ready_cnt_d;
      if (pop_i) entries_q[head_q].ready <= 1'b0;
      if (alloc_i) begin
        entries_q[tail_q].pc    <= alloc_pc_i;
        entries_q[tail_q].ready <= 1'b0;
      end
      if (fill_i) begin
        entries_q[fill_q].instr <= fill_instr_i;
        entries_q[fill_q].ready <= 1'b1;
      end
    end
  end

  assign head_o      = entries_q[head_q];
  assign ready_cnt_o = ready_cnt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers responses and presents {pc, instr} to decode.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  fetch_entry_t     head;
  logic [CNT_W-1:0] ready_cnt;
  logic             pop, accept, resp_drop, resp_fill, credit_ok;
  logic [CNT_W+1:0] committed;

  // Handshakes: a request transfers on a cycle where imem_req_valid and
  // imem_req_ready are both high; valid never depends on ready. Responses are
  // valid-only and always accepted; the credit limit below guarantees room.
  always_comb begin
    pop       = !reset && head.ready && !stall;
    // Drops still count against credit so outstanding memory requests never
    // exceed FQ_DEPTH; a same-cycle pop frees its slot to sustain 1 instr/cycle.
    committed = (CNT_W+2)'(inflight_q) + (CNT_W+2)'(drop_q)
              + (CNT_W+2)'(ready_cnt) - (CNT_W+2)'(pop);
    credit_ok = committed < (CNT_W+2)'(FQ_DEPTH);

    imem_req_valid = !reset && !redirect_valid && credit_ok;
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;

    resp_drop = imem_resp_valid && (drop_q != '0);
    resp_fill = imem_resp_valid && (drop_q == '0) && (inflight_q != '0);

    if_valid = !reset && head.ready;
    if_pc    = if_valid ? head.pc : 32'h0;
    if_instr = if_valid ? head.instr : NOP_INSTR;
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Everything still outstanding becomes wrong-path; a response landing
      // this cycle is itself discarded and retires one of them.
      pc_d       = word_align(redirect_pc);
      inflight_d = '0;
      drop_d     = drop_q + inflight_q
                 - CNT_W'(imem_resp_valid && ((drop_q != '0) || (inflight_q != '0)));
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp_fill);
      drop_d     = drop_q - CNT_W'(resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_buf #(.DEPTH(FQ_DEPTH)) u_fetch_buf (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect_valid),
    .alloc_i      (accept),
    .alloc_pc_i   (pc_q),
    .fill_i       (resp_fill && !redirect_valid),
    .fill_instr_i (imem_resp_data),
    .pop_i        (pop && !redirect_valid),
    .head_o       (head),
    .ready_cnt_o  (ready_cnt)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order memory model with variable latency and
// an expected-PC scoreboard derived from the fetch/redirect rules.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  logic        clk, reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  if_fetch_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec, n_err, cyc, pop_cnt, last_due;
  int          lat_min, lat_max, rdy_mode;
  logic [31:0] mq_addr [$];
  int          mq_due [$];
  logic [31:0] exp_q [$];
  logic [31:0] req_exp, last_pop_pc;
  logic        s_req_v, s_if_v;
  logic [31:0] s_req_a, s_if_pc, s_if_instr;
  logic        hold_prev, redir_prev;
  logic [31:0] hold_pc, hold_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, sample at negedge, update model after edge.
  task automatic cycle();
    logic [31:0] e;
    int due;
    case (rdy_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = (cyc % 2) == 0;
      default: imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clk);
    s_req_v = imem_req_valid; s_req_a = imem_req_addr;
    s_if_v = if_valid; s_if_pc = if_pc; s_if_instr = if_instr;
    if (reset) begin
      chk("rst_req_valid", 32'(s_req_v), 32'd0);
      chk("rst_if_valid", 32'(s_if_v), 32'd0);
      chk("rst_if_pc", s_if_pc, 32'd0);
      chk("rst_if_instr", s_if_instr, NOP_INSTR);
    end else begin
      if (redirect_valid) chk("redirect_no_req", 32'(s_req_v), 32'd0);
      if (redir_prev) chk("post_redirect_if_valid", 32'(s_if_v), 32'd0);
      if (hold_prev) begin
        chk("stall_hold_valid", 32'(s_if_v), 32'd1);
        chk("stall_hold_pc", s_if_pc, hold_pc);
        chk("stall_hold_instr", s_if_instr, hold_instr);
      end
      if (!s_if_v) chk("idle_nop", s_if_instr, NOP_INSTR);
    end
    @(posedge clk);
    if (reset) begin
      mq_addr.delete(); mq_due.delete(); exp_q.delete();
      req_exp = RESET_PC; last_due = 0;
      hold_prev = 1'b0; redir_prev = 1'b0;
    end else begin
      if (imem_resp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (redirect_valid) begin
        exp_q.delete();
        req_exp = {redirect_pc[31:2], 2'b00};
      end else begin
        if (s_req_v && imem_req_ready) begin
          chk("req_addr", s_req_a, req_exp);
          due = cyc + $urandom_range(lat_min, lat_max);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mq_addr.push_back(s_req_a);
          mq_due.push_back(due);
          exp_q.push_back(req_exp);
          req_exp = req_exp + 32'd4;
        end
        if (s_if_v && !stall) begin
          chk("pop_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pop_pc", s_if_pc, e);
            chk("pop_instr", s_if_instr, mem_word(e));
          end
          last_pop_pc = s_if_pc;
          pop_cnt++;
        end
      end
      chk("outstanding_bound", 32'(mq_addr.size() <= FQ_DEPTH), 32'd1);
      hold_prev  = s_if_v && stall && !redirect_valid;
      hold_pc    = s_if_pc;
      hold_instr = s_if_instr;
      redir_prev = redirect_valid;
    end
    cyc++;
    #1;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
    int start;
    int n;
    start = pop_cnt;
    n = 0;
    while (pop_cnt == start && n < 60) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(pop_cnt != start), 32'd1);
    if (pop_cnt != start) chk(tag, last_pop_pc, exp_pc);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0; cyc = 0; pop_cnt = 0; last_due = 0;
    lat_min = 1; lat_max = 1; rdy_mode = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    req_exp = RESET_PC; last_pop_pc = 32'h0;
    hold_prev = 1'b0; redir_prev = 1'b0; hold_pc = 32'h0; hold_instr = 32'h0;
    repeat (3) cycle();

    // reset release, back-to-back fetch with 1-cycle memory
    reset = 1'b0;
    cycle();
    chk("t1_req0_valid", 32'(s_req_v), 32'd1);
    chk("t1_req0_addr", s_req_a, 32'h0);
    chk("t1_if_valid0", 32'(s_if_v), 32'd0);
    cycle();
    chk("t1_req1_addr", s_req_a, 32'h4);
    chk("t1_if_valid1", 32'(s_if_v), 32'd0);
    cycle();
    chk("t1_req2_valid", 32'(s_req_v), 32'd1);
    chk("t1_req2_addr", s_req_a, 32'h8);
    chk("t1_first_valid", 32'(s_if_v), 32'd1);
    chk("t1_first_pc", s_if_pc, 32'h0);
    cycle();
    chk("t1_second_pc", s_if_pc, 32'h4);

    // stall with head at 0x8
    stall = 1'b1;
    cycle();
    chk("t2_head_pc", s_if_pc, 32'h8);
    chk("t2_credit_full0", 32'(s_req_v), 32'd0);
    cycle();
    chk("t2_credit_full1", 32'(s_req_v), 32'd0);
    cycle();
    stall = 1'b0;
    wait_pop("t2_pop_8", 32'h8);
    wait_pop("t2_pop_c", 32'hC);

    // redirect with two requests outstanding, 3-cycle memory
    lat_min = 3; lat_max = 3;
    n = 0;
    while (mq_addr.size() != 2 && n < 20) begin cycle(); n++; end
    chk("t3_two_outstanding", 32'(mq_addr.size()), 32'd2);
    redirect_to(32'h0000_0100);
    wait_pop("t3_target", 32'h0000_0100);

    // redirect coinciding with a response, one more still outstanding
    lat_min = 2; lat_max = 2;
    n = 0;
    while (!(mq_addr.size() == 2 && mq_due[0] <= cyc) && n < 30) begin cycle(); n++; end
    chk("t4_resp_and_one_more", 32'(mq_addr.size() == 2 && mq_due[0] <= cyc), 32'd1);
    redirect_to(32'h0000_0203);
    wait_pop("t4_aligned_target", 32'h0000_0200);

    // toggling ready, 3-cycle latency, address wrap
    rdy_mode = 1; lat_min = 3; lat_max = 3;
    redirect_to(32'hFFFF_FFF8);
    wait_pop("t5_pc_fff8", 32'hFFFF_FFF8);
    wait_pop("t5_pc_fffc", 32'hFFFF_FFFC);
    wait_pop("t5_pc_0", 32'h0000_0000);
    wait_pop("t5_pc_4", 32'h0000_0004);

    // reset mid-stream with a full buffer
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    stall = 1'b1;
    repeat (6) cycle();
    chk("t6_buffered_valid", 32'(s_if_v), 32'd1);
    reset = 1'b1;
    cycle();
    chk("t6_reset_if_valid", 32'(s_if_v), 32'd0);
    chk("t6_reset_nop", s_if_instr, NOP_INSTR);
    cycle();
    reset = 1'b0; stall = 1'b0;
    cycle();
    chk("t6_req_after_reset", 32'(s_req_v), 32'd1);
    chk("t6_addr_after_reset", s_req_a, RESET_PC);
    chk("t6_if_valid_after_reset", 32'(s_if_v), 32'd0);

    // randomized traffic: stalls, ready, latency, redirects
    rdy_mode = 2; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) redirect_to($urandom);
      else cycle();
    end
    stall = 1'b0;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
